lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store unit that issues data-memory accesses on behalf of the core datapath.
- Sits between the execute stage and the word-organised data memory; it is the requester side of the memory interface.
- Converts byte, halfword and word loads/stores into aligned word requests with byte enables.
- Runs a request/grant/response handshake and returns sign- or zero-extended load data with a completion pulse.

Parameters:
- XLEN, 32, data and address width.
- BE_W, XLEN/8, byte-enable width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- lsu_req_i  in  1  core requests an access; sampled only in IDLE.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- lsu_unsigned_i  in  1  load zero-extends when 1 (LBU/LHU).
- lsu_addr_i  in  XLEN  byte address.
- lsu_wdata_i  in  XLEN  store data, right-aligned.
- lsu_rdata_o  out  XLEN  extended load data; valid while lsu_done_o=1.
- lsu_done_o  out  1  one-cycle completion pulse.
- lsu_err_o  out  1  one-cycle misaligned/illegal pulse, coincident with lsu_done_o.
- lsu_busy_o  out  1  high in every state except IDLE.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  write enable.
- mem_be_o  out  BE_W  byte enables.
- mem_addr_o  out  XLEN  word-aligned address, {addr[XLEN-1:2],2'b00}.
- mem_wdata_o  out  XLEN  lane-replicated store data.
- mem_gnt_i  in  1  memory accepted the request.
- mem_rvalid_i  in  1  response valid (read data or write acknowledge).
- mem_rdata_i  in  XLEN  read word.

Behaviour:
- Reset (asynchronous): state=IDLE. All outputs 0, all capture registers 0. Reset mid-transaction abandons the access; mem_req_o drops immediately.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - On lsu_req_i, capture we, size, unsigned, addr[1:0], word address, be and wdata.
  - Aligned access → REQ.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]≠0) or size=11 → RESP with error flag set; no memory request is issued.
- REQ: mem_req_o=1 and all mem_* outputs held stable until mem_gnt_i.
  - gnt with rvalid in the same cycle → RESP (capture data).
  - gnt alone → WAIT.
- WAIT: mem_req_o=0. On mem_rvalid_i, capture and extend rdata → RESP.
- RESP: lsu_done_o=1 for exactly one cycle; lsu_err_o=1 if error flag set; → IDLE.
- lsu_rdata_o is registered and holds until the next capture.
  - Stores return 0.
  - Error completions return 0.
- Minimum latency: lsu_req_i at cycle T, mem_req_o at T+1; with gnt at T+1 and rvalid at T+2, lsu_done_o at T+3. Error path: lsu_done_o and lsu_err_o at T+1.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<addr[1:0].
  - Word: 4'b1111.
  - mem_be_o is driven for loads too; memory ignores it on reads.
- Store data lanes:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- Load extraction:
  - Shift mem_rdata_i right by 8*addr[1:0].
  - Take the low 8 or 16 bits.
  - Sign-extend unless unsigned.
  - Word loads pass through unchanged.
- lsu_req_i while busy is ignored; the core must hold it until done.
- mem_gnt_i outside REQ is ignored.
- mem_rvalid_i outside REQ/WAIT is ignored.
- Memory addresses only the bits it implements; upper-address wrap is a memory concern. The LSU passes the full address.

Decomposition:
- Package lsu_pkg:
  - lsu_size_e: LSU_BYTE=2'b00, LSU_HALF=2'b01, LSU_WORD=2'b10.
  - lsu_state_e: IDLE, REQ, WAIT, RESP.
- Sub-module lsu_align (combinational):
  - Store direction: addr[1:0] + size + wdata → be + wdata lanes.
  - Load direction: addr[1:0] + size + unsigned + rdata → extended data.
  - Unit-testable on its own.
- The FSM and capture registers stay in lsu_mem_master.

Test Plan:
- Word load addr 0x0000_0010, gnt at T+1, rvalid at T+2 with rdata 0xDEAD_BEEF → mem_addr_o=0x10, mem_be_o=4'b1111, lsu_rdata_o=0xDEAD_BEEF, done at T+3, err=0.
- Byte loads from addr 0x13 with rdata 0x80AA_BBCC → LB returns 0xFFFF_FF80; LBU returns 0x0000_0080.
- Half store addr 0x06, wdata 0x1234_ABCD → mem_be_o=4'b1100, mem_wdata_o=0xABCD_ABCD, mem_we_o=1, done one cycle after rvalid.
- Word load addr 0x02 → no mem_req_o ever asserted, lsu_done_o=lsu_err_o=1 at T+1, lsu_rdata_o=0. Repeat with size=11 → same response.
- Grant withheld 3 cycles → mem_req_o, mem_addr_o, mem_be_o and mem_wdata_o stable throughout. lsu_req_i toggled during busy → no second access issued.
- rst_i asserted while in WAIT → all outputs 0 immediately. A later rvalid is ignored. The next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit memory master.
package lsu_pkg;

   typedef enum logic [1:0] {
      LSU_BYTE = 2'b00,
      LSU_HALF = 2'b01,
      LSU_WORD = 2'b10
   } lsu_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10,
      RESP = 2'b11
   } lsu_state_e;

   // Misaligned halves/words and the unused size encoding never reach memory.
   function automatic logic access_bad(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         LSU_BYTE: bad = 1'b0;
         LSU_HALF: bad = off[0];
         LSU_WORD: bad = (off != 2'b00);
         default:  bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/byte-enable generation and load data extraction.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int BE_W = XLEN / 8
) (
   input  logic [1:0]      st_off,
   input  logic [1:0]      st_size,
   input  logic [XLEN-1:0] st_wdata,
   output logic [BE_W-1:0] st_be,
   output logic [XLEN-1:0] st_lanes,
   input  logic [1:0]      ld_off,
   input  logic [1:0]      ld_size,
   input  logic            ld_unsigned,
   input  logic [XLEN-1:0] ld_rdata,
   output logic [XLEN-1:0] ld_data
);

   logic [XLEN-1:0] shifted_s;

   // Store direction: enables shifted to the addressed lanes, data replicated.
   always_comb begin
      st_be    = {BE_W{1'b0}};
      st_lanes = st_wdata;
      case (st_size)
         LSU_BYTE: begin
            st_be    = {{(BE_W-1){1'b0}}, 1'b1} << st_off;
            st_lanes = {BE_W{st_wdata[7:0]}};
         end
         LSU_HALF: begin
            st_be    = {{(BE_W-2){1'b0}}, 2'b11} << st_off;
            st_lanes = {(BE_W/2){st_wdata[15:0]}};
         end
         LSU_WORD: begin
            st_be    = {BE_W{1'b1}};
            st_lanes = st_wdata;
         end
         default: begin
            st_be    = {BE_W{1'b0}};
            st_lanes = st_wdata;
         end
      endcase
   end

   // Load direction: right-justify the addressed lanes, then extend.
   always_comb begin
      shifted_s = ld_rdata >> {ld_off, 3'b000};
      case (ld_size)
         LSU_BYTE: ld_data = ld_unsigned ? {{(XLEN-8){1'b0}}, shifted_s[7:0]}
                                         : {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
         LSU_HALF: ld_data = ld_unsigned ? {{(XLEN-16){1'b0}}, shifted_s[15:0]}
                                         : {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
         LSU_WORD: ld_data = shifted_s;
         default:  ld_data = {XLEN{1'b0}};
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit memory requester: request/grant/response FSM with captured
// access attributes and registered completion outputs.
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int BE_W = XLEN / 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            lsu_req_i,
   input  logic            lsu_we_i,
   input  logic [1:0]      lsu_size_i,
   input  logic            lsu_unsigned_i,
   input  logic [XLEN-1:0] lsu_addr_i,
   input  logic [XLEN-1:0] lsu_wdata_i,
   output logic [XLEN-1:0] lsu_rdata_o,
   output logic            lsu_done_o,
   output logic            lsu_err_o,
   output logic            lsu_busy_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [BE_W-1:0] mem_be_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i
);

   lsu_state_e      state_r, state_s;
   logic            capture_s, rsp_s, bad_s;
   logic            we_r, unsigned_r, err_r;
   logic [1:0]      size_r, off_r;
   logic [XLEN-1:0] addr_r, wdata_r, rdata_r;
   logic [BE_W-1:0] be_r, be_s;
   logic [XLEN-1:0] lanes_s, ld_data_s;
   logic            req_r, busy_r, done_r, err_out_r;

   lsu_align #(.XLEN(XLEN), .BE_W(BE_W)) u_align (
      .st_off      (lsu_addr_i[1:0]),
      .st_size     (lsu_size_i),
      .st_wdata    (lsu_wdata_i),
      .st_be       (be_s),
      .st_lanes    (lanes_s),
      .ld_off      (off_r),
      .ld_size     (size_r),
      .ld_unsigned (unsigned_r),
      .ld_rdata    (mem_rdata_i),
      .ld_data     (ld_data_s)
   );

   assign bad_s = access_bad(lsu_size_i, lsu_addr_i[1:0]);

   // Next-state logic; capture_s/rsp_s mark the cycles that load registers.
   always_comb begin
      state_s   = state_r;
      capture_s = 1'b0;
      rsp_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (lsu_req_i) begin
               capture_s = 1'b1;
               state_s   = bad_s ? RESP : REQ;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            if (mem_gnt_i) begin
               rsp_s   = mem_rvalid_i;
               state_s = mem_rvalid_i ? RESP : WAIT;
            end else begin
               state_s = REQ;
            end
         end
         WAIT: begin
            if (mem_rvalid_i) begin
               rsp_s   = 1'b1;
               state_s = RESP;
            end else begin
               state_s = WAIT;
            end
         end
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State, capture and output registers; outputs follow the next state so
   // they line up with the state they describe.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r    <= IDLE;
         we_r       <= 1'b0;
         unsigned_r <= 1'b0;
         err_r      <= 1'b0;
         size_r     <= 2'b00;
         off_r      <= 2'b00;
         addr_r     <= {XLEN{1'b0}};
         wdata_r    <= {XLEN{1'b0}};
         be_r       <= {BE_W{1'b0}};
         rdata_r    <= {XLEN{1'b0}};
         req_r      <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_out_r  <= 1'b0;
      end else begin
         state_r   <= state_s;
         req_r     <= (state_s == REQ);
         busy_r    <= (state_s != IDLE);
         done_r    <= (state_s == RESP);
         err_out_r <= (state_s == RESP) && (capture_s ? bad_s : err_r);
         if (capture_s) begin
            we_r       <= lsu_we_i;
            unsigned_r <= lsu_unsigned_i;
            err_r      <= bad_s;
            size_r     <= lsu_size_i;
            off_r      <= lsu_addr_i[1:0];
            addr_r     <= {lsu_addr_i[XLEN-1:2], 2'b00};
            wdata_r    <= lanes_s;
            be_r       <= be_s;
            if (bad_s) begin
               rdata_r <= {XLEN{1'b0}};
            end
         end
         if (rsp_s) begin
            rdata_r <= we_r ? {XLEN{1'b0}} : ld_data_s;
         end
      end
   end

   assign lsu_rdata_o = rdata_r;
   assign lsu_done_o  = done_r;
   assign lsu_err_o   = err_out_r;
   assign lsu_busy_o  = busy_r;
   assign mem_req_o   = req_r;
   assign mem_we_o    = we_r;
   assign mem_be_o    = be_r;
   assign mem_addr_o  = addr_r;
   assign mem_wdata_o = wdata_r;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed, table-driven bench for lsu_mem_master with hand-computed expectations.
module tb_lsu_mem_master;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        lsu_req_i, lsu_we_i, lsu_unsigned_i;
   logic [1:0]  lsu_size_i;
   logic [31:0] lsu_addr_i, lsu_wdata_i;
   logic [31:0] lsu_rdata_o;
   logic        lsu_done_o, lsu_err_o, lsu_busy_o;
   logic        mem_req_o, mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   int total = 0;
   int bad   = 0;

   lsu_mem_master dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
      .lsu_unsigned_i(lsu_unsigned_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
      .lsu_rdata_o(lsu_rdata_o), .lsu_done_o(lsu_done_o), .lsu_err_o(lsu_err_o),
      .lsu_busy_o(lsu_busy_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;   // word the memory returns
      int          gwait;   // cycles grant is withheld
      logic        same;    // rvalid together with gnt
      logic        err;
      logic [31:0] maddr;
      logic [3:0]  be;
      logic [31:0] lanes;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " rdata"}, lsu_rdata_o, 32'h0);
      check({tag, " done"}, {31'h0, lsu_done_o}, 32'h0);
      check({tag, " err"}, {31'h0, lsu_err_o}, 32'h0);
      check({tag, " busy"}, {31'h0, lsu_busy_o}, 32'h0);
      check({tag, " mreq"}, {31'h0, mem_req_o}, 32'h0);
      check({tag, " mwe"}, {31'h0, mem_we_o}, 32'h0);
      check({tag, " mbe"}, {28'h0, mem_be_o}, 32'h0);
      check({tag, " maddr"}, mem_addr_o, 32'h0);
      check({tag, " mwdata"}, mem_wdata_o, 32'h0);
   endtask

   task automatic check_mem(input string tag, input vec_t v);
      check({tag, " mreq"}, {31'h0, mem_req_o}, 32'h1);
      check({tag, " mwe"}, {31'h0, mem_we_o}, {31'h0, v.we});
      check({tag, " mbe"}, {28'h0, mem_be_o}, {28'h0, v.be});
      check({tag, " maddr"}, mem_addr_o, v.maddr);
      check({tag, " mwdata"}, mem_wdata_o, v.lanes);
   endtask

   // One access: request in cycle T, then fixed-latency expectations.
   task automatic run_vec(input int idx, input vec_t v);
      string tag;
      tag = $sformatf("v%0d", idx);
      @(negedge clk_i);
      lsu_req_i = 1'b1; lsu_we_i = v.we; lsu_size_i = v.size;
      lsu_unsigned_i = v.uns; lsu_addr_i = v.addr; lsu_wdata_i = v.wdata;
      @(posedge clk_i); #1;
      lsu_req_i = 1'b0;
      if (v.err) begin
         check({tag, " err mreq"}, {31'h0, mem_req_o}, 32'h0);
         check({tag, " err done"}, {31'h0, lsu_done_o}, 32'h1);
         check({tag, " err err"}, {31'h0, lsu_err_o}, 32'h1);
         check({tag, " err rdata"}, lsu_rdata_o, 32'h0);
      end else begin
         check_mem(tag, v);
         check({tag, " busy"}, {31'h0, lsu_busy_o}, 32'h1);
         for (int k = 0; k < v.gwait; k++) begin
            lsu_req_i = ~lsu_req_i;
            lsu_addr_i = lsu_addr_i + 32'h100;
            @(posedge clk_i); #1;
            check_mem({tag, " held"}, v);
         end
         lsu_req_i = 1'b0;
         mem_gnt_i = 1'b1;
         mem_rvalid_i = v.same;
         mem_rdata_i = v.rdata;
         @(posedge clk_i); #1;
         mem_gnt_i = 1'b0;
         if (!v.same) begin
            check({tag, " wait mreq"}, {31'h0, mem_req_o}, 32'h0);
            check({tag, " wait done"}, {31'h0, lsu_done_o}, 32'h0);
            mem_rvalid_i = 1'b1;
            @(posedge clk_i); #1;
         end
         mem_rvalid_i = 1'b0;
         mem_rdata_i = 32'h5A5A_5A5A;
         check({tag, " done"}, {31'h0, lsu_done_o}, 32'h1);
         check({tag, " err"}, {31'h0, lsu_err_o}, 32'h0);
         check({tag, " rdata"}, lsu_rdata_o, v.exp);
      end
      @(posedge clk_i); #1;
      check({tag, " pulse"}, {31'h0, lsu_done_o}, 32'h0);
      check({tag, " err pulse"}, {31'h0, lsu_err_o}, 32'h0);
      check({tag, " idle busy"}, {31'h0, lsu_busy_o}, 32'h0);
      @(posedge clk_i); #1;
      check({tag, " no reissue"}, {31'h0, mem_req_o}, 32'h0);
      check({tag, " rdata hold"}, lsu_rdata_o, v.exp);
   endtask

   initial begin
      //        we    size   uns   addr          wdata         rdata         gw same  err   maddr         be       lanes         exp
      vt[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h1122_3344, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 32'h0000_0010, 4'b1111, 32'h1122_3344, 32'hDEAD_BEEF};
      vt[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'h80AA_BBCC, 0, 1'b0, 1'b0, 32'h0000_0010, 4'b1000, 32'h0000_0000, 32'hFFFF_FF80};
      vt[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0000_0000, 32'h80AA_BBCC, 0, 1'b0, 1'b0, 32'h0000_0010, 4'b1000, 32'h0000_0000, 32'h0000_0080};
      vt[3]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0000_0000, 32'h0,         0, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
      vt[4]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0,         0, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
      vt[5]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 32'h0000_0004, 4'b1100, 32'hABCD_ABCD, 32'h0};
      vt[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0,         32'h8001_1234, 0, 1'b1, 1'b0, 32'h0000_0000, 4'b1100, 32'h0,         32'hFFFF_8001};
      vt[7]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0,         32'h8001_1234, 0, 1'b1, 1'b0, 32'h0000_0000, 4'b1100, 32'h0,         32'h0000_8001};
      vt[8]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h0000_00A5, 32'h0,         3, 1'b0, 1'b0, 32'h0000_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0};
      vt[9]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0005, 32'h0,         32'h0,         0, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
      vt[10] = '{1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_007F, 0, 1'b0, 1'b0, 32'h0000_0000, 4'b0001, 32'h0,         32'h0000_007F};
      vt[11] = '{1'b1, 2'b10, 1'b0, 32'hFFFF_FFF8, 32'hCAFE_F00D, 32'h0,         3, 1'b0, 1'b0, 32'hFFFF_FFF8, 4'b1111, 32'hCAFE_F00D, 32'h0};

      rst_i = 1'b1;
      lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'b00; lsu_unsigned_i = 1'b0;
      lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
      repeat (2) @(posedge clk_i);
      #1;
      check_idle_outputs("reset");
      @(negedge clk_i);
      rst_i = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run_vec(i, vt[i]);
      end

      // Stray handshake signals while idle must not start anything.
      @(negedge clk_i);
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
      @(posedge clk_i); #1;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      check("stray done", {31'h0, lsu_done_o}, 32'h0);
      check("stray busy", {31'h0, lsu_busy_o}, 32'h0);

      // Reset while waiting for the response abandons the access.
      @(negedge clk_i);
      lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = 2'b10; lsu_unsigned_i = 1'b0;
      lsu_addr_i = 32'h0000_0040; lsu_wdata_i = 32'h7777_0001;
      @(posedge clk_i); #1;
      lsu_req_i = 1'b0;
      check("rst pre mreq", {31'h0, mem_req_o}, 32'h1);
      mem_gnt_i = 1'b1;
      @(posedge clk_i); #1;
      mem_gnt_i = 1'b0;
      check("rst wait busy", {31'h0, lsu_busy_o}, 32'h1);
      rst_i = 1'b1;
      #1;
      check_idle_outputs("rst mid");
      @(negedge clk_i);
      rst_i = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
      @(posedge clk_i); #1;
      mem_rvalid_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("late rvalid done", {31'h0, lsu_done_o}, 32'h0);
         check("late rvalid rdata", lsu_rdata_o, 32'h0);
         @(posedge clk_i); #1;
      end
      run_vec(100, vt[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
